// File: rtl/simd_alu_arbiter.sv
// ============================================================================
// simd_alu_arbiter
//
// Shares one SIMD ALU between NUM_REQ requesters. Commands arrive on a
// per-requester valid/ready handshake, are muxed onto the ALU operand/opcode
// inputs in the grant cycle, tracked through the ALU's fixed input-register
// latency, and returned tagged with the requester ID through a response FIFO
// that the consumer can backpressure.
//
// Grants are credit-gated: a command is accepted only while
// (FIFO occupancy + commands still inside the ALU) < RSP_DEPTH, so the FIFO
// can never overflow and the ALU never has to stall.
//
// Configuration macro:
//   SIMD_ALU_ARB_PRIO_EN  defined   -> requester 0 has strict priority, the
//                                      rest share round-robin; the pointer
//                                      does not move on requester-0 grants.
//                         undefined -> pure round-robin over all requesters.
//
// Ports:
//   clk_i          clock (shared with the ALU)
//   rst_i          synchronous, active-high reset (ALU rst_n = ~rst_i)
//   req_valid_i    per-requester command valid
//   req_ready_o    one-hot grant, zero when nothing is granted
//   req_a_i/req_b_i flattened operands, requester i uses slice i
//   req_opcode_i   flattened opcodes
//   alu_a_o/alu_b_o/alu_opcode_o  to ALU in_a/in_b/opcode, zero when idle
//   alu_out_i/alu_ovf_i           from ALU out/out_overflow
//   rsp_valid_o/rsp_ready_i       response handshake
//   rsp_id_o/rsp_data_o/rsp_ovf_o registered response fields
// ============================================================================

module simd_alu_arbiter_chk #(
    parameter int RSP_DEPTH = 4,
    parameter int CNT_W     = 3
) (
    input logic             clk_i,
    input logic             rst_i,
    input logic [CNT_W-1:0] fifo_count_i,
    input logic             push_i,
    input logic             pop_i
);
    a_count_le_depth: assert property (@(posedge clk_i) disable iff (rst_i)
        fifo_count_i <= CNT_W'(RSP_DEPTH));

    a_no_push_full: assert property (@(posedge clk_i) disable iff (rst_i)
        !(push_i && !pop_i && (fifo_count_i == CNT_W'(RSP_DEPTH))));
endmodule

module simd_alu_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int DATA_W    = 256,
    parameter int OPC_W     = 5,
    parameter int ALU_LAT   = 1,
    parameter int RSP_DEPTH = 4
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic [NUM_REQ-1:0]           req_valid_i,
    output logic [NUM_REQ-1:0]           req_ready_o,
    input  logic [NUM_REQ*DATA_W-1:0]    req_a_i,
    input  logic [NUM_REQ*DATA_W-1:0]    req_b_i,
    input  logic [NUM_REQ*OPC_W-1:0]     req_opcode_i,
    output logic [DATA_W-1:0]            alu_a_o,
    output logic [DATA_W-1:0]            alu_b_o,
    output logic [OPC_W-1:0]             alu_opcode_o,
    input  logic [DATA_W-1:0]            alu_out_i,
    input  logic [DATA_W/8-1:0]          alu_ovf_i,
    output logic                         rsp_valid_o,
    input  logic                         rsp_ready_i,
    output logic [$clog2(NUM_REQ)-1:0]   rsp_id_o,
    output logic [DATA_W-1:0]            rsp_data_o,
    output logic [DATA_W/8-1:0]          rsp_ovf_o
);
    localparam int ID_W  = $clog2(NUM_REQ);
    localparam int IDX_W = ID_W + 1;
    localparam int OVF_W = DATA_W / 8;
    localparam int PTR_W = $clog2(RSP_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int SUM_W = CNT_W + 1;
    localparam int INF_W = $clog2(ALU_LAT + 2);
    localparam int ENT_W = ID_W + DATA_W + OVF_W;

    localparam logic [ID_W-1:0]  LAST_ID = ID_W'(NUM_REQ - 1);
    localparam logic [IDX_W-1:0] NREQ_X  = IDX_W'(NUM_REQ);
    localparam logic [SUM_W-1:0] DEPTH_S = SUM_W'(RSP_DEPTH);

    // Registered state
    logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [ALU_LAT-1:0] trk_vld_q, trk_vld_d;
    logic [ID_W-1:0]  trk_id_q [ALU_LAT];
    logic [ID_W-1:0]  trk_id_d [ALU_LAT];
    logic [ENT_W-1:0] fifo_mem_q [RSP_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [ENT_W-1:0] rsp_ent_q, rsp_ent_d;

    // Combinational signals
    logic [INF_W-1:0]   inflight_s;
    logic               credit_ok_s;
    logic [NUM_REQ-1:0] scan_mask_s;
    logic               scan_vld_s;
    logic [ID_W-1:0]    scan_idx_s;
    logic               grant_vld_s;
    logic [ID_W-1:0]    grant_idx_s;
    logic               hs_s;
    logic               adv_ptr_s;
    logic               push_s;
    logic               pop_s;
    logic [ENT_W-1:0]   push_ent_s;

    // Credit: commands inside the ALU plus queued responses must leave a slot.
    always_comb begin
        inflight_s = {INF_W{1'b0}};
        for (int i = 0; i < ALU_LAT; i++) begin
            inflight_s = inflight_s + INF_W'(trk_vld_q[i]);
        end
        credit_ok_s = (({1'b0, count_q} + SUM_W'(inflight_s)) < DEPTH_S);
    end

    // Round-robin scan: first valid requester at or after rr_ptr, with wrap.
    always_comb begin
        logic [IDX_W-1:0] pos;
        pos         = {IDX_W{1'b0}};
        scan_vld_s  = 1'b0;
        scan_idx_s  = {ID_W{1'b0}};
        scan_mask_s = req_valid_i;
`ifdef SIMD_ALU_ARB_PRIO_EN
        // Requester 0 is handled by the priority path, not the rotation.
        scan_mask_s[0] = 1'b0;
`endif
        for (int k = 0; k < NUM_REQ; k++) begin
            pos = {1'b0, rr_ptr_q} + IDX_W'(k);
            if (pos >= NREQ_X) begin
                pos = pos - NREQ_X;
            end else begin
                pos = pos;
            end
            if (!scan_vld_s && scan_mask_s[pos[ID_W-1:0]]) begin
                scan_vld_s = 1'b1;
                scan_idx_s = pos[ID_W-1:0];
            end else begin
                scan_vld_s = scan_vld_s;
            end
        end
    end

    // Final grant selection and handshake qualification.
    always_comb begin
        grant_vld_s = scan_vld_s;
        grant_idx_s = scan_idx_s;
        adv_ptr_s   = 1'b1;
`ifdef SIMD_ALU_ARB_PRIO_EN
        if (req_valid_i[0]) begin
            grant_vld_s = 1'b1;
            grant_idx_s = {ID_W{1'b0}};
            adv_ptr_s   = 1'b0;
        end else begin
            grant_vld_s = scan_vld_s;
            grant_idx_s = scan_idx_s;
            adv_ptr_s   = 1'b1;
        end
`endif
        hs_s = grant_vld_s & credit_ok_s & ~rst_i;
    end

    // Grant decode and ALU operand mux; ALU inputs are zero when idle.
    always_comb begin
        req_ready_o  = {NUM_REQ{1'b0}};
        alu_a_o      = {DATA_W{1'b0}};
        alu_b_o      = {DATA_W{1'b0}};
        alu_opcode_o = {OPC_W{1'b0}};
        if (hs_s) begin
            req_ready_o[grant_idx_s] = 1'b1;
            alu_a_o      = req_a_i[int'(grant_idx_s)*DATA_W +: DATA_W];
            alu_b_o      = req_b_i[int'(grant_idx_s)*DATA_W +: DATA_W];
            alu_opcode_o = req_opcode_i[int'(grant_idx_s)*OPC_W +: OPC_W];
        end else begin
            req_ready_o  = {NUM_REQ{1'b0}};
        end
    end

    // Pointer moves to the requester after the one just served.
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (hs_s && adv_ptr_s) begin
            rr_ptr_d = (grant_idx_s == LAST_ID) ? {ID_W{1'b0}} : grant_idx_s + ID_W'(1);
        end else begin
            rr_ptr_d = rr_ptr_q;
        end
    end

    // Tracker: one stage per ALU cycle; the oldest stage lines up with alu_out.
    always_comb begin
        trk_vld_d = {ALU_LAT{1'b0}};
        for (int i = 0; i < ALU_LAT; i++) begin
            trk_id_d[i] = trk_id_q[i];
        end
        trk_vld_d[0] = hs_s;
        trk_id_d[0]  = grant_idx_s;
        for (int i = 1; i < ALU_LAT; i++) begin
            trk_vld_d[i] = trk_vld_q[i-1];
            trk_id_d[i]  = trk_id_q[i-1];
        end
        push_s     = trk_vld_q[ALU_LAT-1];
        push_ent_s = {trk_id_q[ALU_LAT-1], alu_out_i, alu_ovf_i};
    end

    // Response FIFO bookkeeping and next head-of-queue output register.
    always_comb begin
        pop_s       = rsp_valid_q & rsp_ready_i;
        wr_ptr_d    = push_s ? (wr_ptr_q + PTR_W'(1)) : wr_ptr_q;
        rd_ptr_d    = pop_s  ? (rd_ptr_q + PTR_W'(1)) : rd_ptr_q;
        count_d     = count_q + CNT_W'(push_s) - CNT_W'(pop_s);
        rsp_valid_d = (count_d != {CNT_W{1'b0}});
        rsp_ent_d   = rsp_ent_q;
        if (count_d != {CNT_W{1'b0}}) begin
            // Head slot equal to the write slot means the remaining queue was
            // empty, so the entry being pushed becomes the new head directly.
            if (push_s && (rd_ptr_d == wr_ptr_q)) begin
                rsp_ent_d = push_ent_s;
            end else begin
                rsp_ent_d = fifo_mem_q[rd_ptr_d];
            end
        end else begin
            rsp_ent_d = rsp_ent_q;
        end
    end

    // Control and output registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rr_ptr_q    <= {ID_W{1'b0}};
            trk_vld_q   <= {ALU_LAT{1'b0}};
            for (int i = 0; i < ALU_LAT; i++) begin
                trk_id_q[i] <= {ID_W{1'b0}};
            end
            wr_ptr_q    <= {PTR_W{1'b0}};
            rd_ptr_q    <= {PTR_W{1'b0}};
            count_q     <= {CNT_W{1'b0}};
            rsp_valid_q <= 1'b0;
            rsp_ent_q   <= {ENT_W{1'b0}};
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            trk_vld_q   <= trk_vld_d;
            for (int i = 0; i < ALU_LAT; i++) begin
                trk_id_q[i] <= trk_id_d[i];
            end
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_ent_q   <= rsp_ent_d;
        end
    end

    // FIFO storage; a slot is only ever read after it has been written.
    always_ff @(posedge clk_i) begin
        if (push_s) begin
            fifo_mem_q[wr_ptr_q] <= push_ent_s;
        end
    end

    assign rsp_valid_o                        = rsp_valid_q;
    assign {rsp_id_o, rsp_data_o, rsp_ovf_o}  = rsp_ent_q;

    simd_alu_arbiter_chk #(
        .RSP_DEPTH (RSP_DEPTH),
        .CNT_W     (CNT_W)
    ) u_chk (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .fifo_count_i (count_q),
        .push_i       (push_s),
        .pop_i        (pop_s)
    );
endmodule

// File: tb/tb_simd_alu_arbiter.sv
module tb_simd_alu_arbiter;
    localparam int NR     = 4;
    localparam int DW     = 256;
    localparam int OW     = 5;
    localparam int OVW    = DW / 8;
    localparam int IDW    = 2;
    localparam int DEPTH  = 4;
    localparam int CTRL_W = NR + 2*DW + OW + 1;
    localparam int RSPV_W = IDW + DW + OVW;
`ifdef SIMD_ALU_ARB_PRIO_EN
    localparam bit PRIO = 1'b1;
`else
    localparam bit PRIO = 1'b0;
`endif

    logic clk, rst;
    logic [NR-1:0]    req_valid, req_ready;
    logic [NR*DW-1:0] req_a, req_b;
    logic [NR*OW-1:0] req_opcode;
    logic [DW-1:0]    alu_a, alu_b, alu_out;
    logic [OW-1:0]    alu_opcode;
    logic [OVW-1:0]   alu_ovf;
    logic             rsp_valid, rsp_ready;
    logic [IDW-1:0]   rsp_id;
    logic [DW-1:0]    rsp_data;
    logic [OVW-1:0]   rsp_ovf;

    int checks = 0;
    int failures = 0;

    simd_alu_arbiter #(.NUM_REQ(NR), .DATA_W(DW), .OPC_W(OW), .ALU_LAT(1), .RSP_DEPTH(DEPTH)) dut (
        .clk_i(clk), .rst_i(rst),
        .req_valid_i(req_valid), .req_ready_o(req_ready),
        .req_a_i(req_a), .req_b_i(req_b), .req_opcode_i(req_opcode),
        .alu_a_o(alu_a), .alu_b_o(alu_b), .alu_opcode_o(alu_opcode),
        .alu_out_i(alu_out), .alu_ovf_i(alu_ovf),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
        .rsp_id_o(rsp_id), .rsp_data_o(rsp_data), .rsp_ovf_o(rsp_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural ALU: opcode 0 ADD8 (carry), 1 SUB8 (borrow), 2 XOR, else AND.
    function automatic logic [DW+OVW-1:0] alu_f(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                                input logic [OW-1:0] op);
        logic [DW-1:0]  d;
        logic [OVW-1:0] o;
        logic [8:0]     s;
        d = '0;
        o = '0;
        for (int i = 0; i < OVW; i++) begin
            case (op)
                5'd0: begin s = {1'b0, a[i*8 +: 8]} + {1'b0, b[i*8 +: 8]}; d[i*8 +: 8] = s[7:0]; o[i] = s[8]; end
                5'd1: begin s = {1'b0, a[i*8 +: 8]} - {1'b0, b[i*8 +: 8]}; d[i*8 +: 8] = s[7:0]; o[i] = s[8]; end
                5'd2: d[i*8 +: 8] = a[i*8 +: 8] ^ b[i*8 +: 8];
                default: d[i*8 +: 8] = a[i*8 +: 8] & b[i*8 +: 8];
            endcase
        end
        return {d, o};
    endfunction

    // ALU with one input-register cycle of latency.
    always @(posedge clk) {alu_out, alu_ovf} <= alu_f(alu_a, alu_b, alu_opcode);

    wire [CTRL_W-1:0] obs_ctrl = {req_ready, alu_a, alu_b, alu_opcode, rsp_valid};
    wire [RSPV_W-1:0] obs_rsp  = {rsp_id, rsp_data, rsp_ovf};

    // Reference model: outstanding-command credit, rotating pointer, in-order response queue.
    typedef struct {
        logic [IDW-1:0] id;
        logic [DW-1:0]  d;
        logic [OVW-1:0] o;
        int             due;
    } exp_t;
    exp_t m_q[$];
    int   m_ptr = 0;
    int   m_outst = 0;
    int   cyc = 0;

    task automatic model_eval(output int g, output logic ev, output logic [CTRL_W-1:0] ec,
                              output logic [RSPV_W-1:0] er);
        logic [NR-1:0] rdy;
        logic [DW-1:0] ea, eb;
        logic [OW-1:0] eo;
        g = -1;
        if (!rst && m_outst < DEPTH) begin
            if (PRIO && req_valid[0]) g = 0;
            for (int k = 0; k < NR; k++) begin
                int i;
                i = (m_ptr + k) % NR;
                if (g < 0 && req_valid[i] && !(PRIO && i == 0)) g = i;
            end
        end
        rdy = '0; ea = '0; eb = '0; eo = '0;
        if (g >= 0) begin
            rdy[g] = 1'b1;
            ea = req_a[g*DW +: DW];
            eb = req_b[g*DW +: DW];
            eo = req_opcode[g*OW +: OW];
        end
        ev = (m_q.size() > 0) && (m_q[0].due <= cyc);
        er = '0;
        if (m_q.size() > 0) er = {m_q[0].id, m_q[0].d, m_q[0].o};
        ec = {rdy, ea, eb, eo, ev};
    endtask

    task automatic model_commit(input int g, input logic ev);
        exp_t e;
        if (rst) begin
            m_q.delete();
            m_outst = 0;
            m_ptr = 0;
        end else begin
            if (ev && rsp_ready) begin
                void'(m_q.pop_front());
                m_outst--;
            end
            if (g >= 0) begin
                e.id = IDW'(g);
                {e.d, e.o} = alu_f(req_a[g*DW +: DW], req_b[g*DW +: DW], req_opcode[g*OW +: OW]);
                e.due = cyc + 2;
                m_q.push_back(e);
                m_outst++;
                if (!(PRIO && g == 0)) m_ptr = (g + 1) % NR;
            end
        end
        cyc++;
    endtask

    task automatic drive(input logic [NR-1:0] v, input logic rr);
        req_valid = v;
        rsp_ready = rr;
        for (int i = 0; i < NR*DW/32; i++) begin
            req_a[i*32 +: 32] = $urandom;
            req_b[i*32 +: 32] = $urandom;
        end
        for (int i = 0; i < NR; i++) req_opcode[i*OW +: OW] = OW'($urandom_range(0, 3));
    endtask

    task automatic test_reset();
        int g; logic ev; logic [CTRL_W-1:0] ec; logic [RSPV_W-1:0] er;
        rst = 1'b1;
        drive(4'b1111, 1'b1);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            model_eval(g, ev, ec, er);
            checks++;
            if (obs_ctrl !== ec) begin failures++; $display("FAIL reset_ctrl got=%h exp=%h", obs_ctrl, ec); end
            checks++;
            if (obs_rsp !== {RSPV_W{1'b0}}) begin failures++; $display("FAIL reset_rsp got=%h exp=0", obs_rsp); end
            model_commit(g, ev);
            @(posedge clk); #1;
        end
        rst = 1'b0;
    endtask

    task automatic test_single();
        int g; logic ev; logic [CTRL_W-1:0] ec; logic [RSPV_W-1:0] er;
        int seen;
        seen = -1;
        drive(4'b0100, 1'b1);
        req_a[2*DW +: DW] = 256'h01FF;
        req_b[2*DW +: DW] = 256'h0001;
        req_opcode[2*OW +: OW] = 5'd0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            model_eval(g, ev, ec, er);
            checks++;
            if (obs_ctrl !== ec) begin failures++; $display("FAIL single_ctrl cyc=%0d got=%h exp=%h", cyc, obs_ctrl, ec); end
            if (ev) begin
                checks++;
                if (obs_rsp !== er) begin failures++; $display("FAIL single_rsp got=%h exp=%h", obs_rsp, er); end
            end
            if (k == 0) begin
                checks++;
                if (req_ready !== 4'b0100) begin failures++; $display("FAIL single_grant got=%b exp=0100", req_ready); end
            end
            if (rsp_valid === 1'b1 && seen < 0) begin
                seen = k;
                checks++;
                if (rsp_id !== 2'd2) begin failures++; $display("FAIL single_id got=%0d exp=2", rsp_id); end
                checks++;
                if (rsp_data[15:0] !== 16'h0100) begin failures++; $display("FAIL single_data got=%h exp=0100", rsp_data[15:0]); end
                checks++;
                if (rsp_ovf[1:0] !== 2'b01) begin failures++; $display("FAIL single_ovf got=%b exp=01", rsp_ovf[1:0]); end
            end
            model_commit(g, ev);
            @(posedge clk); #1;
            drive(4'b0000, 1'b1);
        end
        checks++;
        if (seen != 2) begin failures++; $display("FAIL single_latency got=%0d exp=2", seen); end
    endtask

    task automatic test_round_robin();
        int g; logic ev; logic [CTRL_W-1:0] ec; logic [RSPV_W-1:0] er;
        int p0;
        logic [NR-1:0] want;
        p0 = m_ptr;
        drive(4'b1111, 1'b1);
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            model_eval(g, ev, ec, er);
            checks++;
            if (obs_ctrl !== ec) begin failures++; $display("FAIL rr_ctrl cyc=%0d got=%h exp=%h", cyc, obs_ctrl, ec); end
            if (ev) begin
                checks++;
                if (obs_rsp !== er) begin failures++; $display("FAIL rr_rsp got=%h exp=%h", obs_rsp, er); end
            end
            want = '0;
            want[(p0 + k) % NR] = 1'b1;
            checks++;
            if (req_ready !== want) begin failures++; $display("FAIL rr_order k=%0d got=%b exp=%b", k, req_ready, want); end
            model_commit(g, ev);
            @(posedge clk); #1;
            drive(4'b1111, 1'b1);
        end
    endtask

    task automatic test_backpressure();
        int g; logic ev; logic [CTRL_W-1:0] ec; logic [RSPV_W-1:0] er;
        int grants;
        int phase;
        grants = 0;
        for (int k = 0; k < 22; k++) begin
            phase = (k < 4) ? 0 : (k < 12) ? 1 : 2;
            if (phase == 0) drive(4'b0000, 1'b1);
            else if (phase == 1) drive(4'b1111, 1'b0);
            else drive(4'b1111, 1'b1);
            @(negedge clk);
            model_eval(g, ev, ec, er);
            checks++;
            if (obs_ctrl !== ec) begin failures++; $display("FAIL bp_ctrl cyc=%0d got=%h exp=%h", cyc, obs_ctrl, ec); end
            if (ev) begin
                checks++;
                if (obs_rsp !== er) begin failures++; $display("FAIL bp_rsp got=%h exp=%h", obs_rsp, er); end
            end
            if (phase == 1) grants += $countones(req_ready);
            if (k == 11) begin
                checks++;
                if (grants != DEPTH) begin failures++; $display("FAIL bp_grants got=%0d exp=%0d", grants, DEPTH); end
                checks++;
                if (rsp_valid !== 1'b1) begin failures++; $display("FAIL bp_held got=%b exp=1", rsp_valid); end
            end
            if (k == 12) begin
                checks++;
                if (req_ready !== 4'b0000) begin failures++; $display("FAIL bp_full_ready got=%b exp=0000", req_ready); end
            end
            if (k == 13) begin
                checks++;
                if (req_ready === 4'b0000) begin failures++; $display("FAIL bp_resume got=%b exp=nonzero", req_ready); end
            end
            model_commit(g, ev);
            @(posedge clk); #1;
        end
    endtask

    task automatic test_random();
        int g; logic ev; logic [CTRL_W-1:0] ec; logic [RSPV_W-1:0] er;
        for (int k = 0; k < 250; k++) begin
            drive(NR'($urandom), ($urandom_range(0, 9) < 7));
            @(negedge clk);
            model_eval(g, ev, ec, er);
            checks++;
            if (obs_ctrl !== ec) begin failures++; $display("FAIL rand_ctrl cyc=%0d got=%h exp=%h", cyc, obs_ctrl, ec); end
            if (ev) begin
                checks++;
                if (obs_rsp !== er) begin failures++; $display("FAIL rand_rsp cyc=%0d got=%h exp=%h", cyc, obs_rsp, er); end
            end
            model_commit(g, ev);
            @(posedge clk); #1;
        end
    endtask

    task automatic test_mid_reset();
        int g; logic ev; logic [CTRL_W-1:0] ec; logic [RSPV_W-1:0] er;
        for (int k = 0; k < 7; k++) begin
            rst = (k == 2);
            if (k < 4) drive(4'b1111, 1'b1);
            else drive(4'b0000, 1'b1);
            @(negedge clk);
            model_eval(g, ev, ec, er);
            checks++;
            if (obs_ctrl !== ec) begin failures++; $display("FAIL mrst_ctrl cyc=%0d got=%h exp=%h", cyc, obs_ctrl, ec); end
            if (ev) begin
                checks++;
                if (obs_rsp !== er) begin failures++; $display("FAIL mrst_rsp got=%h exp=%h", obs_rsp, er); end
            end
            if (k == 2) begin
                checks++;
                if (req_ready !== 4'b0000) begin failures++; $display("FAIL mrst_ready got=%b exp=0000", req_ready); end
            end
            if (k == 3) begin
                checks++;
                if (req_ready !== 4'b0001) begin failures++; $display("FAIL mrst_first_grant got=%b exp=0001", req_ready); end
            end
            if (k == 3 || k == 4) begin
                checks++;
                if (rsp_valid !== 1'b0) begin failures++; $display("FAIL mrst_no_rsp k=%0d got=%b exp=0", k, rsp_valid); end
            end
            if (k == 5) begin
                checks++;
                if (rsp_valid !== 1'b1 || rsp_id !== 2'd0) begin
                    failures++; $display("FAIL mrst_new_rsp got=%b/%0d exp=1/0", rsp_valid, rsp_id);
                end
            end
            model_commit(g, ev);
            @(posedge clk); #1;
        end
        rst = 1'b0;
    endtask

`ifdef SIMD_ALU_ARB_PRIO_EN
    task automatic test_prio();
        int g; logic ev; logic [CTRL_W-1:0] ec; logic [RSPV_W-1:0] er;
        for (int k = 0; k < 4; k++) begin
            drive((k < 3) ? 4'b1001 : 4'b1000, 1'b1);
            @(negedge clk);
            model_eval(g, ev, ec, er);
            checks++;
            if (obs_ctrl !== ec) begin failures++; $display("FAIL prio_ctrl cyc=%0d got=%h exp=%h", cyc, obs_ctrl, ec); end
            checks++;
            if (req_ready !== ((k < 3) ? 4'b0001 : 4'b1000)) begin
                failures++; $display("FAIL prio_grant k=%0d got=%b", k, req_ready);
            end
            model_commit(g, ev);
            @(posedge clk); #1;
        end
    endtask
`endif

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        req_valid = '0;
        req_a = '0;
        req_b = '0;
        req_opcode = '0;
        rsp_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
`ifdef SIMD_ALU_ARB_PRIO_EN
        test_prio();
`endif
        test_random();
        test_mid_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
